// File: rtl/line_burst_adaptor_pkg.sv
// line_burst_adaptor_pkg: shared cache constants and line/burst adaptor FSM state encodings
package line_burst_adaptor_pkg;

    localparam int DEF_LINE_WIDTH  = 256;
    localparam int DEF_BURST_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH  = 32;

    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_BURST = 3'd1;
    localparam logic [2:0] RD_DONE  = 3'd2;
    localparam logic [2:0] WR_BURST = 3'd3;
    localparam logic [2:0] WR_DONE  = 3'd4;

endpackage

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: converts cache-line fill/writeback requests into memory beat bursts
module line_burst_adaptor
    import line_burst_adaptor_pkg::*;
#(
    parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int OFF   = $clog2(LINE_WIDTH / 8);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wline_q;
    logic [BURST_WIDTH-1:0]  beat_q [BEATS];
    logic [BURST_WIDTH-1:0]  wbeat  [BEATS];
    logic                    in_burst, ack, last;

    assign in_burst = state_q == RD_BURST || state_q == WR_BURST;
    assign ack      = in_burst && resp_i;
    assign last     = ack && count_q == LAST;

    // Next state: requests only sampled in IDLE, write wins; unknown encodings fall back to IDLE
    always_comb begin
        state_d = state_q == IDLE     ? (write_i ? WR_BURST : read_i ? RD_BURST : IDLE)
                : state_q == RD_BURST ? (last ? RD_DONE : RD_BURST)
                : state_q == WR_BURST ? (last ? WR_DONE : WR_BURST)
                : IDLE;
        count_d = (last || !in_burst) ? '0 : count_q + CW'(ack);
    end

    // FSM and beat counter; counter parks at 0 outside bursts so every burst starts at beat 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Request capture happens only on acceptance, so mid-burst input changes cannot disturb it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wline_q <= '0;
        end else if (state_q == IDLE) begin
            if (write_i || read_i)
                addr_q <= address_i;
            if (write_i)
                wline_q <= line_i;
        end
    end

    // Fill buffer: one flop slot per beat, written only by acknowledged read beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BEATS; i++)
                beat_q[i] <= '0;
        end else if (state_q == RD_BURST && resp_i) begin
            beat_q[count_q] <= burst_i;
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_slot
        assign line_o[g*BURST_WIDTH +: BURST_WIDTH] = beat_q[g];
        assign wbeat[g] = wline_q[g*BURST_WIDTH +: BURST_WIDTH];
    end

    assign read_o    = state_q == RD_BURST;
    assign write_o   = state_q == WR_BURST;
    assign resp_o    = state_q == RD_DONE || state_q == WR_DONE;
    assign burst_o   = write_o ? wbeat[count_q] : '0;
    assign address_o = (addr_q >> OFF) << OFF;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// tb_line_burst_adaptor: randomized and directed checks of line_burst_adaptor against a transaction-level model
module tb_line_burst_adaptor;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int BEATS = LW / BW;

    logic          clk = 0;
    logic          rst = 0;
    logic [LW-1:0] line_i = '0;
    logic [LW-1:0] line_o;
    logic [AW-1:0] address_i = '0;
    logic          read_i = 0;
    logic          write_i = 0;
    logic          resp_o;
    logic [BW-1:0] burst_i = '0;
    logic [BW-1:0] burst_o;
    logic [AW-1:0] address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i = 0;

    int vectors = 0;
    int errors  = 0;

    line_burst_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
        .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i),
        .burst_o(burst_o), .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Transaction-level reference: kind of outstanding request, beats acknowledged so far,
    // and whether the completion cycle has been reached
    int            m_kind = 0;
    int            m_acks = 0;
    bit            m_done = 0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wline = '0;
    logic [LW-1:0] m_acc = '0;
    logic [LW-1:0] m_line = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_kind = 0; m_acks = 0; m_done = 0; m_addr = '0; m_line = '0;
        end else if (m_done) begin
            m_done = 0; m_kind = 0;
        end else if (m_kind == 0) begin
            if (write_i || read_i) begin
                m_kind = write_i ? 2 : 1;
                m_addr = address_i;
                m_acks = 0;
                if (write_i) m_wline = line_i;
            end
        end else if (resp_i) begin
            if (m_kind == 1) m_acc[m_acks*BW +: BW] = burst_i;
            m_acks++;
            if (m_acks == BEATS) begin
                m_done = 1;
                if (m_kind == 1) m_line = m_acc;
            end
        end
    end

    always @(negedge clk) begin
        chk("read_o", LW'(read_o), LW'(m_kind == 1 && !m_done));
        chk("write_o", LW'(write_o), LW'(m_kind == 2 && !m_done));
        chk("resp_o", LW'(resp_o), LW'(m_done));
        chk("address_o", LW'(address_o), LW'({m_addr[AW-1:5], 5'b0}));
        chk("burst_o", LW'(burst_o), (m_kind == 2 && !m_done) ? LW'(m_wline[m_acks*BW +: BW]) : '0);
        if (m_kind == 0 || m_done) chk("line_o", line_o, m_line);
    end

    task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [LW-1:0] wl, input logic [LW-1:0] rdat,
                           input int gap, input logic [31:0] pat, input bit use_pat,
                           output int lat, output logic [LW-1:0] wgot, output bit rd_seen);
        int k;
        int cyc;
        @(posedge clk); #1;
        read_i = rd; write_i = wr; address_i = a; line_i = wl;
        resp_i = 1'($urandom_range(1)); burst_i = {$urandom, $urandom};
        @(posedge clk); #1;
        k = 0; cyc = 1; wgot = '0; rd_seen = 0;
        while (!resp_o && cyc < 64) begin
            rd_seen |= read_o;
            resp_i = k < BEATS && (use_pat ? pat[(cyc-1) % 32] : $urandom_range(99) >= gap);
            burst_i = k < BEATS ? rdat[k*BW +: BW] : {$urandom, $urandom};
            if (resp_i) wgot[k*BW +: BW] = burst_o;
            @(posedge clk); #1;
            k += int'(resp_i);
            cyc++;
        end
        if (cyc >= 64) begin
            vectors++; errors++;
            $display("FAIL timeout: no resp_o within %0d cycles", cyc);
        end
        rd_seen |= read_o;
        lat = cyc + 1;
        read_i = 0; write_i = 0; resp_i = 0;
    endtask

    initial begin
        int lat;
        logic [LW-1:0] wgot, rdat, wl;
        bit rd_seen;
        int kind;

        #1 rst = 1;
        #11;
        chk("rst read_o", LW'(read_o), '0);
        chk("rst write_o", LW'(write_o), '0);
        chk("rst resp_o", LW'(resp_o), '0);
        chk("rst address_o", LW'(address_o), '0);
        chk("rst burst_o", LW'(burst_o), '0);
        chk("rst line_o", line_o, '0);
        @(posedge clk); #1 rst = 0;

        rdat = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        run_txn(1, 0, 32'h0000_1234, '0, rdat, 0, 32'hFFFF_FFFF, 1, lat, wgot, rd_seen);
        chk("fill address_o", LW'(address_o), LW'(32'h0000_1220));
        chk("fill resp_o", LW'(resp_o), LW'(1));
        chk("fill latency", LW'(lat), LW'(6));
        chk("fill line_o", line_o, rdat);

        wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        run_txn(0, 1, 32'h0000_8040, wl, '0, 0, 32'hFFFF_FFFF, 1, lat, wgot, rd_seen);
        chk("wb beats", wgot, wl);
        chk("wb write_o after last ack", LW'(write_o), '0);
        chk("wb resp_o", LW'(resp_o), LW'(1));
        chk("wb line_o held", line_o, rdat);

        rdat = {64'h0D0D0D0D0D0D0D0D, 64'h0C0C0C0C0C0C0C0C, 64'h0B0B0B0B0B0B0B0B, 64'h0A0A0A0A0A0A0A0A};
        run_txn(1, 0, 32'h0000_0400, '0, rdat, 0, 32'b1011001, 1, lat, wgot, rd_seen);
        chk("stall latency", LW'(lat), LW'(9));
        chk("stall line_o", line_o, rdat);

        run_txn(1, 1, 32'h0000_0100, wl, '0, 0, 32'hFFFF_FFFF, 1, lat, wgot, rd_seen);
        chk("both read_o seen", LW'(rd_seen), '0);
        chk("both beats", wgot, wl);

        @(posedge clk); #1;
        read_i = 1; address_i = 32'h0000_2000;
        @(posedge clk); #1;
        resp_i = 1; burst_i = 64'h7777_7777_7777_7777;
        @(posedge clk); #1;
        burst_i = 64'h8888_8888_8888_8888;
        @(posedge clk); #1;
        resp_i = 0;
        #3 rst = 1; read_i = 0;
        #1;
        chk("abort read_o", LW'(read_o), '0);
        chk("abort resp_o", LW'(resp_o), '0);
        chk("abort line_o", line_o, '0);
        @(posedge clk); #1 rst = 0;
        rdat = {64'h5858585858585858, 64'h5757575757575757, 64'h5656565656565656, 64'h5555555555555555};
        run_txn(1, 0, 32'h0000_2000, '0, rdat, 0, 32'hFFFF_FFFF, 1, lat, wgot, rd_seen);
        chk("post-abort latency", LW'(lat), LW'(6));
        chk("post-abort line_o", line_o, rdat);

        @(posedge clk); #1;
        resp_i = 1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle read_o", LW'(read_o), '0);
            chk("idle write_o", LW'(write_o), '0);
            chk("idle resp_o", LW'(resp_o), '0);
            chk("idle address_o", LW'(address_o), LW'(32'h0000_2000));
            chk("idle line_o", line_o, rdat);
        end
        resp_i = 0;

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(2);
            rdat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            wl   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_txn(kind != 1, kind != 0, $urandom, wl, rdat, $urandom_range(60), '0, 0, lat, wgot, rd_seen);
            if (kind == 0) chk("rand line_o", line_o, rdat);
            else begin
                chk("rand beats", wgot, wl);
                chk("rand read_o seen", LW'(rd_seen), '0);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/line_burst_adaptor.md
LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 The block SHALL use parameter LINE_WIDTH, default 256, as the cache line width in bits.
REQ-002 The block SHALL use parameter BURST_WIDTH, default 64, as the memory beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH (default 4).
REQ-003 The block SHALL use parameter ADDR_WIDTH, default 32, as the byte address width.
REQ-004 clk  input  1  the single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 line_i  input  LINE_WIDTH  cache line to write back.
REQ-007 line_o  output  LINE_WIDTH  assembled fill line; valid while resp_o is high.
REQ-008 address_i  input  ADDR_WIDTH  cache-side byte address of the request.
REQ-009 read_i / write_i  input  1 each  cache-side fill / writeback request, held until resp_o.
REQ-010 resp_o  output  1  one-cycle completion pulse to the cache.
REQ-011 burst_i  input  BURST_WIDTH  memory read beat.
REQ-012 burst_o  output  BURST_WIDTH  memory write beat.
REQ-013 address_o  output  ADDR_WIDTH  line-aligned memory address.
REQ-014 read_o / write_o  output  1 each  memory-side burst request.
REQ-015 resp_i  input  1  memory beat acknowledge; one beat transferred per cycle it is high.

Function
REQ-016 FSM states SHALL be IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
REQ-017 IDLE: write_i high -> latch line_i and address_i, go WR_BURST; else read_i high -> latch address_i, go RD_BURST; write SHALL win when both are high.
REQ-018 address_o SHALL equal the latched address with its low log2(LINE_WIDTH/8) bits forced to 0 (bits [4:0] at defaults).
REQ-019 RD_BURST: read_o SHALL be high; each cycle resp_i is high, burst_i SHALL be stored in beat slot count (slot 0 = bits [BURST_WIDTH-1:0]) and count SHALL increment.
REQ-020 On the cycle the beat with count = BEATS-1 is captured, the FSM SHALL go RD_DONE and read_o SHALL drop the following cycle.
REQ-021 RD_DONE: resp_o SHALL be high exactly one cycle with line_o holding all BEATS beats; then IDLE.
REQ-022 WR_BURST: write_o SHALL be high and burst_o SHALL equal latched line slot count; count SHALL advance on each resp_i; after beat BEATS-1 acknowledged go WR_DONE.
REQ-023 WR_DONE: resp_o high exactly one cycle; then IDLE.
REQ-024 Minimum latency from request acceptance to resp_o SHALL be BEATS+2 cycles (back-to-back resp_i); gaps in resp_i SHALL stall count with no data loss.
REQ-025 resp_i while in IDLE, RD_DONE or WR_DONE SHALL be ignored.
REQ-026 read_i/write_i changes while not in IDLE SHALL be ignored; latched address/line SHALL not change mid-burst.
REQ-027 read_o and write_o SHALL never be high in the same cycle; resp_o SHALL never be high outside *_DONE.
REQ-028 count SHALL be log2(BEATS) bits, reset to 0 on entry to each burst, no wrap past BEATS-1.
REQ-029 line_o SHALL hold its last assembled value until the next fill overwrites it.

Reset
REQ-030 rst high SHALL immediately force state IDLE, count 0, read_o 0, write_o 0, resp_o 0, address_o 0, burst_o 0, line_o 0, independent of clk.
REQ-031 Reset mid-burst SHALL abort the transfer with no resp_o; the first request after rst deasserts SHALL start a fresh burst from beat 0.

Structure
REQ-032 The FSM state enum and default width constants SHALL live in the shared cache package.
REQ-033 The block SHALL be a single module with no sub-modules; the beat buffer SHALL be a flop array indexed by count.

Verification
REQ-034 Fill: read_i, address_i=0x0000_1234, resp_i high 4 cycles with burst_i=0x11..,0x22..,0x33..,0x44.. -> address_o=0x0000_1220, resp_o at cycle 6, line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-035 Writeback: write_i, line_i=256'hD..C..B..A (beats A,B,C,D) -> burst_o A,B,C,D on successive acks, write_o drops after 4th ack, one resp_o pulse.
REQ-036 Stalled fill: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, resp_o once after last ack.
REQ-037 Simultaneous read_i and write_i in IDLE -> write_o asserts, read_o stays 0 for whole transaction.
REQ-038 rst pulse after 2 read beats -> read_o low immediately, no resp_o; new read completes normally with all 4 fresh beats.
REQ-039 Spurious resp_i in IDLE -> no state change, outputs unchanged.
